// File: rtl/mic_delay_bank.sv
// mic_delay_bank
// Per-channel programmable integer delay bank for the microphone-array
// beamformer. Every channel keeps its last DEPTH samples in a circular
// buffer sharing one write pointer; each channel is emitted delayed by its
// own runtime delay, and the full-precision sum of all delayed channels is
// emitted one cycle after that.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (clears buffers, delays, outputs)
//   in_valid   one-cycle strobe: one new sample per channel on in_data
//   in_data    CHANNELS x WIDTH signed samples, channel c at [c*WIDTH +: WIDTH]
//   cfg_we     delay write strobe
//   cfg_ch     channel index for the delay write
//   cfg_delay  requested delay in samples (clamped to DEPTH-1)
//   out_valid  strobe, 1 cycle after each in_valid
//   out_data   delayed samples, same packing as in_data
//   sum_valid  strobe, 2 cycles after each in_valid
//   sum_data   signed sum of all out_data channels (SW bits, cannot overflow)
//   cfg_err    one-cycle pulse, 1 cycle after a clamped or ignored write
module mic_delay_bank #(
    parameter int WIDTH    = 19,
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 32,
    localparam int DW      = $clog2(DEPTH),
    localparam int CW      = $clog2(CHANNELS),
    localparam int SW      = WIDTH + CW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      cfg_we,
    input  logic [CW-1:0]             cfg_ch,
    input  logic [DW:0]               cfg_delay,
    output logic                      out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      sum_valid,
    output logic [SW-1:0]             sum_data,
    output logic                      cfg_err
);

    // Requested delays beyond the buffer are clamped to the deepest slot.
    function automatic logic [DW-1:0] sat_delay(input logic [DW:0] v);
        if (v > (DW+1)'(DEPTH - 1)) return DW'(DEPTH - 1);
        else                        return v[DW-1:0];
    endfunction

    function automatic logic delay_over(input logic [DW:0] v);
        return v > (DW+1)'(DEPTH - 1);
    endfunction

    logic signed [WIDTH-1:0] mem [CHANNELS][DEPTH];
    logic        [DW-1:0]    dly [CHANNELS];
    logic        [DW-1:0]    wp;

    logic signed [WIDTH-1:0] rd_p0 [CHANNELS];
    logic                    ch_ok;

    logic signed [WIDTH-1:0] od_p1 [CHANNELS];
    logic                    vld_p1;
    logic                    err_p1;
    logic signed [SW-1:0]    sum_p1;

    logic signed [SW-1:0]    sum_p2;
    logic                    vld_p2;

    // Only meaningful when CHANNELS is not a power of two.
    assign ch_ok = ({1'b0, cfg_ch} < (CW+1)'(CHANNELS));

    // ---- stage p0: buffer read (zero delay bypasses the buffer) ----
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (dly[c] == '0)
                rd_p0[c] = $signed(in_data[c*WIDTH +: WIDTH]);
            else
                rd_p0[c] = mem[c][wp - dly[c]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int a = 0; a < DEPTH; a++)
                    mem[c][a] <= '0;
            wp <= '0;
        end else if (in_valid) begin
            for (int c = 0; c < CHANNELS; c++)
                mem[c][wp] <= $signed(in_data[c*WIDTH +: WIDTH]);
            wp <= wp + 1'b1;
        end
    end

    // Delay registers: a write takes effect from the next strobe because the
    // read above uses the value held before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++)
                dly[c] <= '0;
            err_p1 <= 1'b0;
        end else begin
            err_p1 <= cfg_we && (!ch_ok || delay_over(cfg_delay));
            if (cfg_we && ch_ok)
                dly[cfg_ch] <= sat_delay(cfg_delay);
        end
    end

    // ---- stage p1: registered delayed samples ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++)
                od_p1[c] <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                for (int c = 0; c < CHANNELS; c++)
                    od_p1[c] <= rd_p0[c];
            end
        end
    end

    always_comb begin
        sum_p1 = '0;
        for (int c = 0; c < CHANNELS; c++)
            sum_p1 = sum_p1 + $signed({{CW{od_p1[c][WIDTH-1]}}, od_p1[c]});
    end

    // ---- stage p2: registered sum ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_p2 <= '0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1)
                sum_p2 <= sum_p1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_pack
            assign out_data[g*WIDTH +: WIDTH] = od_p1[g];
        end
    endgenerate

    assign out_valid = vld_p1;
    assign sum_valid = vld_p2;
    assign sum_data  = sum_p2;
    assign cfg_err   = err_p1;

endmodule
